sipo_frame_ctrl: RTL and testbench

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

---
 rtl/sipo_frame_ctrl.sv | 92 +++++++++
 tb/tb_sipo_frame_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out word assembler gated by a frame level, with a one-word output buffer.
// Latency: a completed word appears on out_data/out_valid one cycle after its last bit is accepted.
// Backpressure: out_valid/out_ready handshake; a word completing while the buffer is held is dropped and flagged by overrun.
module sipo_frame_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame,
    input  logic                     sin_valid,
    input  logic                     sin_data,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     busy,
    output logic                     overrun,
    output logic                     short_frame
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_next;
    logic             accept;
    logic             last_bit;
    logic             word_done;
    logic             buf_free;
    logic             partial_drop;

    assign accept       = frame && sin_valid;
    assign last_bit     = (bit_cnt == CW'(WIDTH - 1));
    assign word_done    = accept && last_bit;
    assign buf_free     = !out_valid || out_ready;
    assign partial_drop = !frame && (bit_cnt != '0);

    // Shift register contents plus the bit arriving this cycle
    assign word_next = MSB_FIRST ? {shreg[WIDTH-2:0], sin_data}
                                 : {sin_data, shreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACTIVE;
            ACTIVE:  if (!frame) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            overrun     <= word_done && !buf_free;
            short_frame <= partial_drop;

            if (accept) begin
                shreg   <= word_next;
                bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
            end else if (partial_drop) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end

            // Loading has priority over draining so a same-cycle swap keeps out_valid high
            if (word_done && buf_free) begin
                out_data  <= word_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst, frame, sin_valid, sin_data, out_ready;

    logic [W-1:0] out_data_m, out_data_l;
    logic         out_valid_m, out_valid_l;
    logic [2:0]   bit_cnt_m, bit_cnt_l;
    logic         busy_m, busy_l;
    logic         overrun_m, overrun_l;
    logic         short_m, short_l;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .frame(frame), .sin_valid(sin_valid), .sin_data(sin_data),
        .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .bit_cnt(bit_cnt_m), .busy(busy_m), .overrun(overrun_m), .short_frame(short_m)
    );

    sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .frame(frame), .sin_valid(sin_valid), .sin_data(sin_data),
        .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .bit_cnt(bit_cnt_l), .busy(busy_l), .overrun(overrun_l), .short_frame(short_l)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: word value built arithmetically from the bit stream
    int          m_cnt  = 0;
    int unsigned m_accm = 0, m_accl = 0;
    int unsigned m_dm   = 0, m_dl   = 0;
    bit          m_vld = 0, m_busy = 0, m_over = 0, m_short = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rs, input bit f, input bit v, input bit d, input bit r);
        bit acc, cons, load;
        if (rs) begin
            m_cnt = 0; m_accm = 0; m_accl = 0; m_dm = 0; m_dl = 0;
            m_vld = 0; m_busy = 0; m_over = 0; m_short = 0;
        end else begin
            acc  = f && v;
            cons = m_vld && r;
            load = 0;
            m_over  = 0;
            m_short = 0;
            if (acc) begin
                m_accm = m_accm * 2 + (d ? 1 : 0);
                m_accl = m_accl + (d ? (32'd1 << m_cnt) : 0);
                m_cnt++;
                m_busy = 1;
                if (m_cnt == W) begin
                    if (!m_vld || r) begin
                        load = 1;
                        m_dm = m_accm;
                        m_dl = m_accl;
                    end else begin
                        m_over = 1;
                    end
                    m_cnt = 0; m_accm = 0; m_accl = 0;
                end
            end else if (!f) begin
                m_busy = 0;
                if (m_cnt != 0) begin
                    m_short = 1;
                    m_cnt = 0; m_accm = 0; m_accl = 0;
                end
            end
            m_vld = load ? 1'b1 : (cons ? 1'b0 : m_vld);
        end
    endtask

    task automatic check_all();
        chk("data_msb",  32'(out_data_m),  m_dm);
        chk("data_lsb",  32'(out_data_l),  m_dl);
        chk("valid_msb", 32'(out_valid_m), 32'(m_vld));
        chk("valid_lsb", 32'(out_valid_l), 32'(m_vld));
        chk("cnt_msb",   32'(bit_cnt_m),   32'(m_cnt));
        chk("cnt_lsb",   32'(bit_cnt_l),   32'(m_cnt));
        chk("busy",      32'(busy_m),      32'(m_busy));
        chk("busy_lsb",  32'(busy_l),      32'(m_busy));
        chk("overrun",   32'(overrun_m),   32'(m_over));
        chk("overrun_l", 32'(overrun_l),   32'(m_over));
        chk("short",     32'(short_m),     32'(m_short));
        chk("short_l",   32'(short_l),     32'(m_short));
    endtask

    task automatic cyc(input bit rs, input bit f, input bit v, input bit d, input bit r);
        @(negedge clk);
        rst = rs; frame = f; sin_valid = v; sin_data = d; out_ready = r;
        @(posedge clk);
        model_step(rs, f, v, d, r);
        #1;
        check_all();
    endtask

    // Sends a word first-bit-first in order w[7]..w[0]; ready may differ on the last bit
    task automatic send(input logic [7:0] w, input bit r_early, input bit r_last);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b1, w[7-i], (i == 7) ? r_last : r_early);
        end
    endtask

    initial begin
        rst = 1'b1; frame = 1'b0; sin_valid = 1'b0; sin_data = 1'b0; out_ready = 1'b0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        chk("rst_data",  32'(out_data_m),  32'h0);
        chk("rst_valid", 32'(out_valid_m), 32'h0);
        chk("rst_cnt",   32'(bit_cnt_m),   32'h0);
        chk("rst_busy",  32'(busy_m),      32'h0);

        // Basic MSB-first word and LSB-first view of the same bits
        send(8'hA5, 1'b1, 1'b1);
        chk("basic_data", 32'(out_data_m),  32'hA5);
        chk("basic_vld",  32'(out_valid_m), 32'h1);
        chk("basic_cnt",  32'(bit_cnt_m),   32'h0);
        chk("lsb_a5",     32'(out_data_l),  32'hA5);
        cyc(0, 1, 0, 0, 1);
        chk("basic_drop", 32'(out_valid_m), 32'h0);
        send(8'hC0, 1'b1, 1'b1);
        chk("lsb_03", 32'(out_data_l), 32'h03);
        chk("msb_c0", 32'(out_data_m), 32'hC0);
        cyc(0, 0, 0, 0, 1);

        // Backpressure and overrun
        send(8'h3C, 1'b0, 1'b0);
        send(8'hC3, 1'b0, 1'b0);
        chk("ovr_data",  32'(out_data_m),  32'h3C);
        chk("ovr_vld",   32'(out_valid_m), 32'h1);
        chk("ovr_pulse", 32'(overrun_m),   32'h1);
        cyc(0, 1, 0, 0, 0);
        chk("ovr_end",   32'(overrun_m),   32'h0);
        cyc(0, 1, 0, 0, 1);
        chk("ovr_drain", 32'(out_valid_m), 32'h0);

        // Simultaneous drain and load
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b1);
        chk("swap_data", 32'(out_data_m),  32'h22);
        chk("swap_vld",  32'(out_valid_m), 32'h1);
        chk("swap_ovr",  32'(overrun_m),   32'h0);
        cyc(0, 1, 0, 0, 1);

        // Short frame with a buffered word held
        send(8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("short_pulse", 32'(short_m),     32'h1);
        chk("short_cnt",   32'(bit_cnt_m),   32'h0);
        chk("short_busy",  32'(busy_m),      32'h0);
        chk("short_vld",   32'(out_valid_m), 32'h1);
        chk("short_keep",  32'(out_data_m),  32'h77);
        cyc(0, 0, 0, 0, 1);
        chk("short_end",   32'(short_m),     32'h0);
        send(8'hF0, 1'b1, 1'b1);
        chk("short_next",  32'(out_data_m),  32'hF0);

        // Reset mid-word with a buffered word
        send(8'h99, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 0);
        cyc(1, 1, 1, 1, 1);
        chk("mrst_data", 32'(out_data_m),  32'h0);
        chk("mrst_vld",  32'(out_valid_m), 32'h0);
        chk("mrst_cnt",  32'(bit_cnt_m),   32'h0);
        chk("mrst_busy", 32'(busy_m),      32'h0);
        send(8'h5A, 1'b1, 1'b1);
        chk("mrst_next", 32'(out_data_m),  32'h5A);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
